regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 14 +
 rtl/regfile_rd_mux.sv | 30 +++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_mp_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NRD    = 2;
    localparam int DEF_NWR    = 2;

endpackage

// File: rtl/regfile_rd_mux.sv
// One read port: write-through bypass, zero-register masking and clear blanking.
import regfile_mp_pkg::*;

module regfile_rd_mux #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NWR      = DEF_NWR,
    parameter int ZERO_REG = 1
) (
    input  logic                     ready,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR*ADDR_W-1:0]    wr_addr,
    input  logic [NWR*DATA_W-1:0]    wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    always_comb begin
        rd_data = mem_data;
        // Ascending scan so the highest-numbered matching port wins.
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr))
                rd_data = wr_data[p*DATA_W +: DATA_W];
        end
        if (!ready || ((ZERO_REG != 0) && (rd_addr == '0)))
            rd_data = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a self-clearing sweep after reset or on request.
import regfile_mp_pkg::*;

module regfile_mp #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = DEF_NRD,
    parameter int NWR      = DEF_NWR,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR*ADDR_W-1:0]    wr_addr,
    input  logic [NWR*DATA_W-1:0]    wr_data,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic                     ready,
    output logic [ADDR_W-1:0]        clr_idx
);

    localparam int DEPTH = 2**ADDR_W;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_idx_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            ST_CLEAR: begin
                if (clr_req) begin
                    clr_idx_nxt = '0;
                end else if (clr_idx == '1) begin
                    state_nxt   = ST_READY;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            ST_READY: begin
                clr_idx_nxt = '0;
                if (clr_req)
                    state_nxt = ST_CLEAR;
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_idx_nxt = '0;
            end
        endcase
    end

    assign ready = (state == ST_READY);

    // Reset forces CLEAR asynchronously, so no user write can land while rst is high.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && !((ZERO_REG != 0) && (wr_addr[p*ADDR_W +: ADDR_W] == '0)))
                    mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [DATA_W-1:0] mem_q;
        assign mem_q = mem[rd_addr[i*ADDR_W +: ADDR_W]];

        regfile_rd_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .ready    (ready),
            .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
            .mem_data (mem_q),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, clear/reset sequences, random vs model.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        ready;
    logic [4:0]  clr_idx;

    int pass_cnt = 0;
    int total_cnt = 0;

    regfile_mp dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .ready   (ready),
        .clr_idx (clr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents, ready flag and sweep position as plain variables.
    logic [31:0] mdl_mem [32];
    bit          mdl_ready;
    int          mdl_idx;

    function automatic logic [31:0] mdl_rd(input int a);
        logic [31:0] r;
        if (!mdl_ready || a == 0) return 32'h0;
        r = mdl_mem[a];
        if (wr_en[0] && int'(wr_addr[4:0]) == a) r = wr_data[31:0];
        if (wr_en[1] && int'(wr_addr[9:5]) == a) r = wr_data[63:32];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic clr, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        clr_req = clr;
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0};
    endtask

    // One clock edge; the model advances using the inputs that were stable at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mdl_ready = 0;
            mdl_idx   = 0;
        end else if (!mdl_ready) begin
            mdl_mem[mdl_idx] = 32'h0;
            if (clr_req) mdl_idx = 0;
            else if (mdl_idx == 31) begin mdl_ready = 1; mdl_idx = 0; end
            else mdl_idx++;
        end else begin
            if (wr_en[0] && wr_addr[4:0] != 0) mdl_mem[wr_addr[4:0]] = wr_data[31:0];
            if (wr_en[1] && wr_addr[9:5] != 0) mdl_mem[wr_addr[9:5]] = wr_data[63:32];
            if (clr_req) begin mdl_ready = 0; mdl_idx = 0; end
        end
        #1;
    endtask

    typedef struct {
        logic        clr;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        erdy;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{1'b0, 2'b01, 5'd5, 32'd6,        5'd0, 32'd0,        5'd5, 5'd6, 32'd6,      32'd0,      1'b1};
        tbl[1] = '{1'b0, 2'b01, 5'd6, 32'd7,        5'd0, 32'd0,        5'd5, 5'd6, 32'd6,      32'd7,      1'b1};
        tbl[2] = '{1'b0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0,        5'd5, 5'd6, 32'd6,      32'd7,      1'b1};
        tbl[3] = '{1'b0, 2'b11, 5'd3, 32'hAAAA,     5'd3, 32'h5555,     5'd3, 5'd3, 32'h5555,   32'h5555,   1'b1};
        tbl[4] = '{1'b0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0,        5'd3, 5'd5, 32'h5555,   32'd6,      1'b1};
        tbl[5] = '{1'b0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'd0,      32'd0,      1'b1};
        tbl[6] = '{1'b0, 2'b00, 5'd0, 32'd0,        5'd0, 32'd0,        5'd0, 5'd3, 32'd0,      32'h5555,   1'b1};
        tbl[7] = '{1'b0, 2'b10, 5'd9, 32'h999,      5'd9, 32'h123,      5'd9, 5'd9, 32'h123,    32'h123,    1'b1};
        tbl[8] = '{1'b0, 2'b01, 5'd9, 32'hBEEF,     5'd9, 32'hDEAD,     5'd9, 5'd7, 32'hBEEF,   32'd0,      1'b1};

        rst = 1'b1;
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        mdl_ready = 0;
        mdl_idx   = 0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'hx;
        #12;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_idx", {27'd0, clr_idx}, 32'd0);
        tick();
        rst = 1'b0;

        // Reset sweep: ready stays low until the edge that clears the last entry.
        for (int k = 1; k <= 32; k++) begin
            drive(0, 2'b00, 0, 0, 0, 0, 5'(k), 5'(k + 7));
            #1;
            chk("sweep_rd0", rd_data[31:0], 32'd0);
            tick();
            chk("sweep_ready", {31'd0, ready}, (k == 32) ? 32'd1 : 32'd0);
            chk("sweep_idx", {27'd0, clr_idx}, 32'(k % 32));
        end

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].clr, tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].ra0, tbl[i].ra1);
            #1;
            chk($sformatf("tbl%0d_rd0", i), rd_data[31:0], tbl[i].e0);
            chk($sformatf("tbl%0d_rd1", i), rd_data[63:32], tbl[i].e1);
            chk($sformatf("tbl%0d_ready", i), {31'd0, ready}, {31'd0, tbl[i].erdy});
            tick();
        end

        // Clear restart: r7 written, clear, writes during CLEAR, restart after 10 cycles.
        drive(0, 2'b01, 5'd7, 32'd9, 0, 0, 5'd7, 5'd0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 5'd7, 5'd0);
        #1;
        chk("r7_written", rd_data[31:0], 32'd9);
        drive(1, 2'b00, 0, 0, 0, 0, 5'd7, 5'd8);
        tick();
        chk("clr_ready_low", {31'd0, ready}, 32'd0);
        chk("clr_idx_zero", {27'd0, clr_idx}, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            drive(0, 2'b11, 5'd8, 32'h77, 5'd7, 32'h55, 5'd7, 5'd8);
            #1;
            chk("clr_rd_blank", rd_data[31:0] | rd_data[63:32], 32'd0);
            tick();
        end
        chk("clr_mid_idx", {27'd0, clr_idx}, 32'd9);
        drive(1, 2'b00, 0, 0, 0, 0, 5'd7, 5'd8);
        tick();
        chk("restart_idx", {27'd0, clr_idx}, 32'd0);
        drive(0, 2'b00, 0, 0, 0, 0, 5'd7, 5'd8);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk("restart_len", 32'(n), 32'd32);
        #1;
        chk("r7_cleared", rd_data[31:0], 32'd0);
        chk("r8_lost", rd_data[63:32], 32'd0);

        // Async reset mid-sweep takes effect between edges.
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_idx", {27'd0, clr_idx}, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ready", {31'd0, ready}, 32'd0);
        chk("async_idx", {27'd0, clr_idx}, 32'd0);
        mdl_ready = 0;
        mdl_idx   = 0;
        tick();
        rst = 1'b0;

        // Random traffic against the model, addresses biased low to force collisions.
        for (int c = 0; c < 500; c++) begin
            drive(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            chk("rnd_rd0", rd_data[31:0], mdl_rd(int'(rd_addr[4:0])));
            chk("rnd_rd1", rd_data[63:32], mdl_rd(int'(rd_addr[9:5])));
            chk("rnd_ready", {31'd0, ready}, {31'd0, mdl_ready});
            chk("rnd_idx", {27'd0, clr_idx}, 32'(mdl_idx));
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
